// File: rtl/ir_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ir_fetch_pkg
// Shared definitions for the instruction fetch stage: the fetch state
// encoding, default widths and the default instruction memory base address.
// Optional feature macro used by importers: IR_FETCH_PREFETCH_EN.
// ----------------------------------------------------------------------------
package ir_fetch_pkg;

    localparam int          MEM_SIZE        = 10;
    localparam int          DATA_SIZE       = 32;
    localparam int          IM_ADDR_SIZE    = 10;
    localparam int          TOTAL_IR_W      = 16;
    localparam int unsigned IM_BASE_DEFAULT = 32'h0000_0080;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/ir_prefetch_buf.sv
// ----------------------------------------------------------------------------
// ir_prefetch_buf
// One-entry instruction buffer holding a speculatively fetched word for the
// fetch stage. Flush has priority over load. Only built when the
// IR_FETCH_PREFETCH_EN macro is defined; otherwise this file is empty.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset (empties the buffer)
//   flush      in   discard the buffered word
//   load       in   capture load_data and mark the buffer full
//   load_data  in   DataSize  word to capture
//   buf_valid  out  buffer holds a word
//   buf_data   out  DataSize  buffered word
// ----------------------------------------------------------------------------
`ifdef IR_FETCH_PREFETCH_EN
module ir_prefetch_buf
    import ir_fetch_pkg::*;
#(
    parameter int DataSize = DATA_SIZE
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                load,
    input  logic [DataSize-1:0] load_data,
    output logic                buf_valid,
    output logic [DataSize-1:0] buf_data
);

    logic                valid_r;
    logic [DataSize-1:0] data_r;

    // Buffer storage: flush empties, load fills, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign buf_valid = valid_r;
    assign buf_data  = data_r;

endmodule
`endif

// File: rtl/ir_fetch_unit.sv
// ----------------------------------------------------------------------------
// ir_fetch_unit
// Instruction fetch stage feeding the multi-cycle instruction controller.
// Owns the 1-based program counter, issues reads to instruction memory with a
// ready handshake and presents one instruction (PC/ir) at a time. Once all
// total_ir instructions are delivered it presents ir = 0 with prog_done set.
// All outputs are registered.
//
// Optional macro IR_FETCH_PREFETCH_EN: speculatively reads instruction PC+1
// into a one-entry buffer (ir_prefetch_buf) while PC is presented.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   start       in   begin program from instruction #1 (IDLE/DONE only)
//   total_ir    in   16  program length, latched on accepted start
//   fetch_req   in   controller consumes the presented instruction
//   im_rdata    in   DataSize  instruction memory read data
//   im_ready    in   read data valid this cycle
//   PC          out  MemSize  1-based number of presented instruction, 0 idle
//   ir          out  DataSize  presented instruction
//   ir_valid    out  ir/PC consumable
//   im_enable   out  memory enable
//   im_fetch    out  memory read strobe
//   im_address  out  IMAddrSize  IM_BASE + target PC - 1 (wraps)
//   busy        out  fetching or presenting (not IDLE, not DONE)
//   prog_done   out  whole program delivered
// ----------------------------------------------------------------------------
module ir_fetch_unit
    import ir_fetch_pkg::*;
#(
    parameter int          MemSize    = MEM_SIZE,
    parameter int          DataSize   = DATA_SIZE,
    parameter int          IMAddrSize = IM_ADDR_SIZE,
    parameter int unsigned IM_BASE    = IM_BASE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           total_ir,
    input  logic                  fetch_req,
    input  logic [DataSize-1:0]   im_rdata,
    input  logic                  im_ready,
    output logic [MemSize-1:0]    PC,
    output logic [DataSize-1:0]   ir,
    output logic                  ir_valid,
    output logic                  im_enable,
    output logic                  im_fetch,
    output logic [IMAddrSize-1:0] im_address,
    output logic                  busy,
    output logic                  prog_done
);

    localparam logic [MemSize-1:0] PC_MAX = {MemSize{1'b1}};

    // Memory address of 1-based instruction number pc (modulo address space).
    function automatic logic [IMAddrSize-1:0] target_addr(input logic [MemSize-1:0] pc);
        logic [31:0] sum;
        sum = IM_BASE + 32'(pc) - 32'd1;
        return sum[IMAddrSize-1:0];
    endfunction

    fetch_state_t          state_r;
    logic [MemSize-1:0]    pc_r;
    logic [MemSize-1:0]    total_r;
    logic [DataSize-1:0]   ir_r;
    logic                  ir_valid_r;
    logic                  im_enable_r;
    logic                  im_fetch_r;
    logic [IMAddrSize-1:0] addr_r;
    logic                  busy_r;
    logic                  prog_done_r;

    logic [MemSize-1:0]    total_clamp_s;
    logic [MemSize-1:0]    pc_next_s;
    logic                  start_accept_s;

    // Program lengths beyond what PC can count are clamped to PC_MAX.
    always_comb begin
        if (32'(total_ir) > 32'(PC_MAX)) begin
            total_clamp_s = PC_MAX;
        end else begin
            total_clamp_s = MemSize'(total_ir);
        end
    end

    // Saturating PC increment.
    always_comb begin
        if (pc_r == PC_MAX) begin
            pc_next_s = PC_MAX;
        end else begin
            pc_next_s = pc_r + MemSize'(1);
        end
    end

    assign start_accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

`ifdef IR_FETCH_PREFETCH_EN
    logic                pf_busy_r;   // speculative read outstanding (incl. strobe cycle)
    logic                pf_ready_s;
    logic                buf_load_s;
    logic                buf_flush_s;
    logic                buf_valid_s;
    logic [DataSize-1:0] buf_data_s;

    // The response cycle can never coincide with our own strobe cycle.
    assign pf_ready_s  = (state_r == ST_VALID) && pf_busy_r && !im_fetch_r && im_ready;
    // A response arriving together with fetch_req bypasses the buffer.
    assign buf_load_s  = pf_ready_s && !fetch_req;
    assign buf_flush_s = start_accept_s || ((state_r == ST_VALID) && fetch_req && buf_valid_s);

    ir_prefetch_buf #(
        .DataSize (DataSize)
    ) u_prefetch_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (buf_flush_s),
        .load      (buf_load_s),
        .load_data (im_rdata),
        .buf_valid (buf_valid_s),
        .buf_data  (buf_data_s)
    );
`endif

    // Fetch sequencer: state, PC, presented instruction and memory strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= '0;
            total_r     <= '0;
            ir_r        <= '0;
            ir_valid_r  <= 1'b0;
            im_enable_r <= 1'b0;
            im_fetch_r  <= 1'b0;
            addr_r      <= IMAddrSize'(IM_BASE);
            busy_r      <= 1'b0;
            prog_done_r <= 1'b0;
`ifdef IR_FETCH_PREFETCH_EN
            pf_busy_r   <= 1'b0;
`endif
        end else begin
            // Memory strobes are single-cycle pulses unless re-asserted below.
            im_enable_r <= 1'b0;
            im_fetch_r  <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        total_r     <= total_clamp_s;
                        prog_done_r <= 1'b0;
`ifdef IR_FETCH_PREFETCH_EN
                        pf_busy_r   <= 1'b0;
`endif
                        if (total_clamp_s == '0) begin
                            // Empty program: straight to DONE, nothing fetched.
                            state_r     <= ST_DONE;
                            pc_r        <= '0;
                            ir_r        <= '0;
                            ir_valid_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            prog_done_r <= 1'b1;
                        end else begin
                            state_r     <= ST_REQ;
                            pc_r        <= MemSize'(1);
                            ir_valid_r  <= 1'b0;
                            im_enable_r <= 1'b1;
                            im_fetch_r  <= 1'b1;
                            addr_r      <= target_addr(MemSize'(1));
                            busy_r      <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end

                ST_REQ: begin
                    state_r <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (im_ready) begin
                        ir_r       <= im_rdata;
                        ir_valid_r <= 1'b1;
                        state_r    <= ST_VALID;
`ifdef IR_FETCH_PREFETCH_EN
                        if (pc_r < total_r) begin
                            im_enable_r <= 1'b1;
                            im_fetch_r  <= 1'b1;
                            addr_r      <= target_addr(pc_next_s);
                            pf_busy_r   <= 1'b1;
                        end else begin
                            pf_busy_r   <= 1'b0;
                        end
`endif
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                ST_VALID: begin
                    if (fetch_req) begin
                        if (pc_r < total_r) begin
                            pc_r <= pc_next_s;
`ifdef IR_FETCH_PREFETCH_EN
                            pf_busy_r <= 1'b0;
                            if (buf_valid_s || pf_ready_s) begin
                                // Next word already here: present it next cycle.
                                ir_r       <= buf_valid_s ? buf_data_s : im_rdata;
                                ir_valid_r <= 1'b1;
                                state_r    <= ST_VALID;
                                if (pc_next_s < total_r) begin
                                    im_enable_r <= 1'b1;
                                    im_fetch_r  <= 1'b1;
                                    addr_r      <= target_addr(pc_next_s + MemSize'(1));
                                    pf_busy_r   <= 1'b1;
                                end else begin
                                    pf_busy_r   <= 1'b0;
                                end
                            end else if (pf_busy_r) begin
                                // Read already on the bus for this PC: just wait for it.
                                ir_valid_r <= 1'b0;
                                state_r    <= ST_WAIT;
                            end else begin
                                ir_valid_r  <= 1'b0;
                                state_r     <= ST_REQ;
                                im_enable_r <= 1'b1;
                                im_fetch_r  <= 1'b1;
                                addr_r      <= target_addr(pc_next_s);
                            end
`else
                            ir_valid_r  <= 1'b0;
                            state_r     <= ST_REQ;
                            im_enable_r <= 1'b1;
                            im_fetch_r  <= 1'b1;
                            addr_r      <= target_addr(pc_next_s);
`endif
                        end else begin
                            // Last instruction consumed: PC stays at total_ir.
                            state_r     <= ST_DONE;
                            ir_r        <= '0;
                            ir_valid_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            prog_done_r <= 1'b1;
`ifdef IR_FETCH_PREFETCH_EN
                            pf_busy_r   <= 1'b0;
`endif
                        end
                    end else begin
                        state_r <= ST_VALID;
`ifdef IR_FETCH_PREFETCH_EN
                        if (pf_ready_s) begin
                            pf_busy_r <= 1'b0;
                        end else begin
                            pf_busy_r <= pf_busy_r;
                        end
`endif
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    pc_r        <= '0;
                    ir_r        <= '0;
                    ir_valid_r  <= 1'b0;
                    addr_r      <= IMAddrSize'(IM_BASE);
                    busy_r      <= 1'b0;
                    prog_done_r <= 1'b0;
`ifdef IR_FETCH_PREFETCH_EN
                    pf_busy_r   <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign PC         = pc_r;
    assign ir         = ir_r;
    assign ir_valid   = ir_valid_r;
    assign im_enable  = im_enable_r;
    assign im_fetch   = im_fetch_r;
    assign im_address = addr_r;
    assign busy       = busy_r;
    assign prog_done  = prog_done_r;

endmodule
